fifo_wr_feeder: RTL and testbench

- Write-domain front end of the async FIFO. Sits directly upstream of the FIFO write controller.
- Accepts a valid/ready word stream from the producer and buffers it in a 2-entry skid buffer.
- Drives the write controller's winc with the matching write data, honouring its registered wfull flag.
- Keeps word and packet counters and a sticky stall-error flag for status.

---
 rtl/fifo_wr_feeder.sv | 128 ++++++++++++
 tb/tb_fifo_wr_feeder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_feeder.sv
// fifo_wr_feeder: write-domain front end of the async FIFO.
// Skid-buffers a valid/ready stream and paces winc against wfull.
module fifo_wr_feeder #(
  parameter int DATA_WIDTH  = 8,
  parameter bit SAFE_GAP    = 1'b1,
  parameter int STALL_LIMIT = 64
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  pkt_done,
  output logic [15:0]           word_cnt,
  output logic [7:0]            pkt_cnt,
  output logic                  stall_err,
  input  logic                  clr_err
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP,
    BLOCKED
  } state_t;

  localparam logic        GAP_EN = SAFE_GAP;
  localparam logic [15:0] LIMIT  = 16'(STALL_LIMIT);

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [1:0]            buf_last;
  logic                  head;
  logic [1:0]            count, count_nx;
  logic                  winc_q;
  logic [15:0]           stall_cnt;

  logic pending;
  logic accept;
  logic gap;
  logic tail;
  logic stalled;
  logic stall_hit;

  assign pending   = count != 2'd0;
  assign s_ready   = count != 2'd2;
  assign accept    = s_valid & s_ready;
  assign gap       = GAP_EN & winc_q;
  // wfull is registered upstream, so winc must react to it combinationally
  assign winc      = pending & ~wfull & ~gap;
  assign wdata     = pending ? buf_data[head] : '0;
  assign pkt_done  = winc & buf_last[head];
  assign tail      = head ^ count[0];
  assign stalled   = pending & wfull;
  assign stall_hit = stalled && (stall_cnt == LIMIT - 16'd1);

  always_comb begin
    count_nx = count;
    unique case ({accept, winc})
      2'b10:   count_nx = count + 2'd1;
      2'b01:   count_nx = count - 2'd1;
      default: count_nx = count;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (count_nx != 2'd0) state_nx = XFER;
      end
      XFER: begin
        if (winc && GAP_EN)         state_nx = GAP;
        else if (stalled)           state_nx = BLOCKED;
        else if (count_nx == 2'd0)  state_nx = IDLE;
      end
      GAP: begin
        if (count_nx == 2'd0) state_nx = IDLE;
        else if (wfull)       state_nx = BLOCKED;
        else                  state_nx = XFER;
      end
      BLOCKED: begin
        if (!wfull) state_nx = XFER;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst) begin
      state       <= IDLE;
      count       <= 2'd0;
      head        <= 1'b0;
      winc_q      <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last    <= 2'b00;
      word_cnt    <= 16'd0;
      pkt_cnt     <= 8'd0;
      stall_cnt   <= 16'd0;
      stall_err   <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      winc_q <= winc;
      if (winc) begin
        head     <= ~head;
        word_cnt <= word_cnt + 16'd1;
        if (buf_last[head]) pkt_cnt <= pkt_cnt + 8'd1;
      end
      if (accept) begin
        buf_data[tail] <= s_data;
        buf_last[tail] <= s_last;
      end
      if (!stalled)               stall_cnt <= 16'd0;
      else if (stall_cnt != LIMIT) stall_cnt <= stall_cnt + 16'd1;
      // a fresh stall outranks a simultaneous clear
      if (stall_hit)    stall_err <= 1'b1;
      else if (clr_err) stall_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_feeder.sv
// tb_fifo_wr_feeder: SAFE_GAP=1 and SAFE_GAP=0 feeders driven by
// directed and random streams, scored against a queue model.
module tb_fifo_wr_feeder;

  localparam int DW  = 8;
  localparam int LIM = 64;
  localparam int NWRAP = 65538;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } ent_t;

  logic w_clk = 1'b0;
  logic w_rst = 1'b0;
  logic wfull = 1'b0;
  logic clr_err = 1'b0;

  logic          s_valid   [2];
  logic [DW-1:0] s_data    [2];
  logic          s_last    [2];
  logic          s_ready   [2];
  logic          winc      [2];
  logic [DW-1:0] wdata     [2];
  logic          pkt_done  [2];
  logic [15:0]   word_cnt  [2];
  logic [7:0]    pkt_cnt   [2];
  logic          stall_err [2];

  always #5 w_clk = ~w_clk;

  fifo_wr_feeder #(.DATA_WIDTH(DW), .SAFE_GAP(1'b1), .STALL_LIMIT(LIM)) u_gap (
    .w_clk(w_clk), .w_rst(w_rst),
    .s_valid(s_valid[0]), .s_data(s_data[0]), .s_last(s_last[0]),
    .s_ready(s_ready[0]), .wfull(wfull), .winc(winc[0]),
    .wdata(wdata[0]), .pkt_done(pkt_done[0]), .word_cnt(word_cnt[0]),
    .pkt_cnt(pkt_cnt[0]), .stall_err(stall_err[0]), .clr_err(clr_err)
  );

  fifo_wr_feeder #(.DATA_WIDTH(DW), .SAFE_GAP(1'b0), .STALL_LIMIT(LIM)) u_nogap (
    .w_clk(w_clk), .w_rst(w_rst),
    .s_valid(s_valid[1]), .s_data(s_data[1]), .s_last(s_last[1]),
    .s_ready(s_ready[1]), .wfull(wfull), .winc(winc[1]),
    .wdata(wdata[1]), .pkt_done(pkt_done[1]), .word_cnt(word_cnt[1]),
    .pkt_cnt(pkt_cnt[1]), .stall_err(stall_err[1]), .clr_err(clr_err)
  );

  // reference model: words accepted but not yet written, in order
  ent_t mq  [2][$];
  ent_t src [2][$];
  int   wc [2];
  int   pc [2];
  int   streak [2];
  bit   er [2];
  bit   pw [2];
  bit   acc [2];
  int   left [2];
  int   vpct [2];
  int   lpct [2];

  bit            saw_nr [2];
  int            nw [2];
  int            fw [2];
  int            lw [2];
  int            pdn [2];
  logic [DW-1:0] pdd [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc %0d got %0h want %0h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic step(int i);
    int   pend;
    bit   ew;
    ent_t hd;
    ent_t e;
    if (!w_rst) begin
      mq[i].delete();
      wc[i] = 0;
      pc[i] = 0;
      streak[i] = 0;
      er[i] = 0;
      pw[i] = 0;
      acc[i] = 0;
      return;
    end
    pend = mq[i].size();
    hd = (pend != 0) ? mq[i][0] : '0;
    ew = (pend != 0) && !wfull && !((i == 0) && pw[i]);
    chk("s_ready", i, 32'(s_ready[i]), 32'(pend != 2));
    chk("winc", i, 32'(winc[i]), 32'(ew));
    chk("wdata", i, 32'(wdata[i]), 32'(hd.d));
    chk("pkt_done", i, 32'(pkt_done[i]), 32'(ew && hd.l));
    chk("word_cnt", i, 32'(word_cnt[i]), 32'(wc[i]));
    chk("pkt_cnt", i, 32'(pkt_cnt[i]), 32'(pc[i]));
    chk("stall_err", i, 32'(stall_err[i]), 32'(er[i]));
    if (winc[i] === 1'b1) begin
      nw[i]++;
      if (fw[i] < 0) fw[i] = cyc;
      lw[i] = cyc;
    end
    if (pkt_done[i] === 1'b1) begin
      pdn[i]++;
      pdd[i] = wdata[i];
    end
    if (s_ready[i] !== 1'b1) saw_nr[i] = 1;
    if (ew) begin
      void'(mq[i].pop_front());
      wc[i] = (wc[i] + 1) % 65536;
      if (hd.l) pc[i] = (pc[i] + 1) % 256;
    end
    if (pend != 0 && wfull) streak[i]++;
    else streak[i] = 0;
    if (streak[i] == LIM) er[i] = 1;
    else if (clr_err) er[i] = 0;
    pw[i] = ew;
    acc[i] = s_valid[i] && s_ready[i];
    if (acc[i]) begin
      e.d = s_data[i];
      e.l = s_last[i];
      mq[i].push_back(e);
    end
  endtask

  always @(negedge w_clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) step(i);
  end

  task automatic produce();
    ent_t e;
    for (int i = 0; i < 2; i++) begin
      if (acc[i] || !s_valid[i]) begin
        if (src[i].size() != 0) begin
          e = src[i].pop_front();
          s_valid[i] = 1'b1;
          s_data[i] = e.d;
          s_last[i] = e.l;
        end else if (left[i] > 0 && $urandom_range(99) < vpct[i]) begin
          s_valid[i] = 1'b1;
          s_data[i] = DW'($urandom);
          s_last[i] = $urandom_range(99) < lpct[i];
          left[i]--;
        end else begin
          s_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge w_clk);
    #1;
    produce();
  endtask

  function automatic bit idle();
    bit r = 1;
    for (int i = 0; i < 2; i++)
      if (src[i].size() != 0 || left[i] != 0 || s_valid[i] || mq[i].size() != 0)
        r = 0;
    return r;
  endfunction

  task automatic drain(int bound);
    int n = 0;
    while (!idle() && n < bound) begin
      cycle();
      n++;
    end
    checks++;
    if (!idle()) begin
      errors++;
      $display("FAIL drain timeout after %0d cycles", bound);
    end
  endtask

  task automatic put(int i, logic [DW-1:0] d, logic l);
    ent_t e;
    e.d = d;
    e.l = l;
    src[i].push_back(e);
  endtask

  task automatic clr_stats();
    for (int i = 0; i < 2; i++) begin
      saw_nr[i] = 0;
      nw[i] = 0;
      fw[i] = -1;
      lw[i] = -1;
      pdn[i] = 0;
      pdd[i] = '0;
    end
  endtask

  task automatic hold(int n, logic exp);
    int b = 0;
    wfull = 1'b1;
    put(0, 8'hC3, 1'b0);
    put(0, 8'h3C, 1'b1);
    while (streak[0] < n && b < 500) begin
      cycle();
      b++;
    end
    wfull = 1'b0;
    chk("hold_streak", 0, 32'(streak[0]), 32'(n));
    drain(100);
    chk("hold_err", 0, 32'(stall_err[0]), 32'(exp));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 1'b0;
      s_data[i] = '0;
      s_last[i] = 1'b0;
      left[i] = 0;
      vpct[i] = 100;
      lpct[i] = 0;
    end
    clr_stats();

    w_rst = 1'b0;
    repeat (3) cycle();
    w_rst = 1'b1;
    repeat (10) cycle();
    @(negedge w_clk);
    chk("idle_winc", 0, 32'(winc[0]), 32'd0);
    chk("idle_ready", 0, 32'(s_ready[0]), 32'd1);
    chk("idle_wcnt", 0, 32'(word_cnt[0]), 32'd0);
    chk("idle_err", 0, 32'(stall_err[0]), 32'd0);

    // three-word packet through the gapped feeder
    clr_stats();
    put(0, 8'h11, 1'b0);
    put(0, 8'h22, 1'b0);
    put(0, 8'h33, 1'b1);
    drain(100);
    chk("t2_wcnt", 0, 32'(word_cnt[0]), 32'd3);
    chk("t2_pcnt", 0, 32'(pkt_cnt[0]), 32'd1);
    chk("t2_pdn", 0, 32'(pdn[0]), 32'd1);
    chk("t2_pdd", 0, 32'(pdd[0]), 32'h33);
    chk("t2_nw", 0, 32'(nw[0]), 32'd3);
    chk("t2_span", 0, 32'(lw[0] - fw[0]), 32'd4);
    chk("t2_notready", 0, 32'(saw_nr[0]), 32'd1);

    // continuous stream through the ungapped feeder
    clr_stats();
    for (int k = 0; k < 20; k++) put(1, DW'(k * 7 + 3), k == 19);
    drain(100);
    chk("t3_notready", 1, 32'(saw_nr[1]), 32'd0);
    chk("t3_nw", 1, 32'(nw[1]), 32'd20);
    chk("t3_span", 1, 32'(lw[1] - fw[1]), 32'd19);
    chk("t3_wcnt", 1, 32'(word_cnt[1]), 32'd20);
    chk("t3_pcnt", 1, 32'(pkt_cnt[1]), 32'd1);

    // stall threshold
    hold(LIM - 1, 1'b0);
    hold(LIM, 1'b1);
    repeat (5) cycle();
    chk("err_sticky", 0, 32'(stall_err[0]), 32'd1);
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    chk("err_clr", 0, 32'(stall_err[0]), 32'd0);

    // reset with two words buffered and winc high
    wfull = 1'b1;
    put(0, 8'hA5, 1'b0);
    put(0, 8'h5A, 1'b1);
    for (int b = 0; b < 50 && mq[0].size() != 2; b++) cycle();
    chk("rst_buffered", 0, 32'(mq[0].size()), 32'd2);
    wfull = 1'b0;
    w_rst = 1'b0;
    @(negedge w_clk);
    chk("rst_winc_hi", 0, 32'(winc[0]), 32'd1);
    chk("rst_full", 0, 32'(s_ready[0]), 32'd0);
    cycle();
    w_rst = 1'b1;
    @(negedge w_clk);
    chk("rst_winc", 0, 32'(winc[0]), 32'd0);
    chk("rst_ready", 0, 32'(s_ready[0]), 32'd1);
    chk("rst_wcnt", 0, 32'(word_cnt[0]), 32'd0);
    chk("rst_pcnt", 0, 32'(pkt_cnt[0]), 32'd0);
    repeat (5) cycle();
    chk("rst_nowrite", 0, 32'(word_cnt[0]), 32'd0);

    // random traffic with random backpressure and clears
    for (int i = 0; i < 2; i++) begin
      left[i] = 400;
      vpct[i] = 60;
      lpct[i] = 30;
    end
    for (int k = 0; k < 1500; k++) begin
      cycle();
      if (k >= 700 && k < 780) wfull = 1'b1;
      else wfull = $urandom_range(99) < 25;
      clr_err = $urandom_range(99) < 3;
    end
    wfull = 1'b0;
    clr_err = 1'b0;
    drain(3000);

    // counter wrap on the ungapped feeder
    w_rst = 1'b0;
    cycle();
    w_rst = 1'b1;
    left[1] = NWRAP;
    vpct[1] = 100;
    lpct[1] = 100;
    drain(NWRAP + 2000);
    chk("wrap_wcnt", 1, 32'(word_cnt[1]), 32'(NWRAP % 65536));
    chk("wrap_pcnt", 1, 32'(pkt_cnt[1]), 32'(NWRAP % 256));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
